// File: rtl/barret_pkg.sv
// Shared constants and response type for the Barrett mod-2423 reduction arbiter.
package barret_pkg;

    localparam int DIN_W    = 23;
    localparam int DOUT_W   = 12;
    localparam int T_W      = 12;
    localparam int ID_MAX_W = 3;
    localparam int Q        = 2423;
    localparam int MU       = 6924;
    localparam int QQ_BOUND = Q * Q;

    typedef struct packed {
        logic [DOUT_W-1:0]   data;
        logic [ID_MAX_W-1:0] id;
        logic                err;
    } rsp_t;

endpackage

// File: rtl/barret_pipe_2423.sv
// Three-stage Barrett reduction pipeline: operand capture, quotient estimate, remainder fix-up.
module barret_pipe_2423 #(
    parameter int ID_W = 2,
    parameter int Q    = barret_pkg::Q,
    parameter int MU   = barret_pkg::MU
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [barret_pkg::DIN_W-1:0]  in_data,
    input  logic [ID_W-1:0]               in_id,
    input  logic                          advance,
    output logic                          out_valid,
    output logic [barret_pkg::DOUT_W-1:0] out_data,
    output logic [ID_W-1:0]               out_id,
    output logic                          out_err
);
    import barret_pkg::*;

    localparam logic [23:0]      MU_W  = 24'(MU);
    localparam logic [23:0]      Q_W   = 24'(Q);
    localparam logic [DIN_W-1:0] Q_D   = DIN_W'(Q);
    localparam logic [DIN_W-1:0] Q2_D  = DIN_W'(2 * Q);
    localparam logic [DIN_W-1:0] BOUND = DIN_W'(Q * Q);

    logic             s1_valid_q, s1_valid_d;
    logic [DIN_W-1:0] s1_din_q, s1_din_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic             s2_valid_q, s2_valid_d;
    logic [DIN_W-1:0] s2_din_q, s2_din_d;
    logic [T_W-1:0]   s2_t_q, s2_t_d;
    logic [ID_W-1:0]  s2_id_q, s2_id_d;
    logic             s3_valid_q, s3_valid_d;
    rsp_t             s3_rsp_q, s3_rsp_d;
    logic [DIN_W-1:0] r;
    rsp_t             res;

    always_comb begin
        r   = DIN_W'({1'b0, s2_din_q} - ({12'b0, s2_t_q} * Q_W));
        res = '0;
        res.id = ID_MAX_W'(s2_id_q);
        // The truncated quotient can undershoot by up to two, so the remainder may reach 3Q-1.
        if (s2_din_q >= BOUND) begin
            res.err  = 1'b1;
            res.data = '0;
        end else if (r >= Q2_D) begin
            res.data = DOUT_W'(r - Q2_D);
        end else if (r >= Q_D) begin
            res.data = DOUT_W'(r - Q_D);
        end else begin
            res.data = DOUT_W'(r);
        end

        s1_valid_d = s1_valid_q;
        s1_din_d   = s1_din_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_din_d   = s2_din_q;
        s2_t_d     = s2_t_q;
        s2_id_d    = s2_id_q;
        s3_valid_d = s3_valid_q;
        s3_rsp_d   = s3_rsp_q;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_din_d   = in_data;
            s1_id_d    = in_id;
            s2_valid_d = s1_valid_q;
            s2_din_d   = s1_din_q;
            s2_t_d     = T_W'(({13'b0, s1_din_q[DIN_W-1:12]} * MU_W) >> 12);
            s2_id_d    = s1_id_q;
            s3_valid_d = s2_valid_q;
            s3_rsp_d   = res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_din_q   <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_din_q   <= '0;
            s2_t_q     <= '0;
            s2_id_q    <= '0;
            s3_valid_q <= 1'b0;
            s3_rsp_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_din_q   <= s1_din_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_din_q   <= s2_din_d;
            s2_t_q     <= s2_t_d;
            s2_id_q    <= s2_id_d;
            s3_valid_q <= s3_valid_d;
            s3_rsp_q   <= s3_rsp_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_data  = s3_rsp_q.data;
    assign out_id    = ID_W'(s3_rsp_q.id);
    assign out_err   = s3_rsp_q.err;

endmodule

// File: rtl/barret_2423_arbiter.sv
// Round-robin arbiter feeding one shared mod-2423 reduction pipeline; stalls globally on backpressure.
module barret_2423_arbiter #(
    parameter int N_REQ = 4,
    parameter int Q     = barret_pkg::Q,
    parameter int MU    = barret_pkg::MU,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ*barret_pkg::DIN_W-1:0]  req_data,
    output logic [N_REQ-1:0]                    req_ready,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [barret_pkg::DOUT_W-1:0]       rsp_data,
    output logic [ID_W-1:0]                     rsp_id,
    output logic                                rsp_err
);
    import barret_pkg::*;

    logic             stall;
    logic             found;
    logic             accept;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DIN_W-1:0] din_sel;

    // Search wraps naturally in ID_W bits because N_REQ is a power of two.
    always_comb begin : arb
        logic [ID_W-1:0] idx;
        stall    = rsp_valid && !rsp_ready;
        found    = 1'b0;
        grant_id = rr_ptr_q;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = rr_ptr_q + ID_W'(k);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end

        accept    = found && !stall && !rst;
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end

        din_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                din_sel = req_data[i*DIN_W +: DIN_W];
            end
        end

        rr_ptr_d = accept ? grant_id + ID_W'(1) : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    barret_pipe_2423 #(
        .ID_W (ID_W),
        .Q    (Q),
        .MU   (MU)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_data   (din_sel),
        .in_id     (grant_id),
        .advance   (!stall),
        .out_valid (rsp_valid),
        .out_data  (rsp_data),
        .out_id    (rsp_id),
        .out_err   (rsp_err)
    );

endmodule
